// File: rtl/mul_issue_pkg.sv
// Shared types and constants for the MUL/DIV issue slice.
package mul_issue_pkg;

    localparam logic [6:0] OPC_OP = 7'b0110011;

    typedef enum logic [1:0] {
        MIS_IDLE     = 2'd0,
        MIS_HOLD     = 2'd1,
        MIS_INFLIGHT = 2'd2
    } mis_state_e;

    // RV32M lives in the OP major opcode with funct7 bit 0 set.
    function automatic logic is_m_op(input logic [6:0] opcode, input logic funct7_b0);
        return (opcode == OPC_OP) && funct7_b0;
    endfunction

endpackage

// File: rtl/mul_issue_cmp.sv
// Hazard comparator: flags a query that touches the outstanding destination register.
module mul_issue_cmp (
    input  logic       pend_vld,
    input  logic [4:0] pend_rd,
    input  logic [4:0] chk_rs0,
    input  logic [4:0] chk_rs1,
    input  logic [4:0] chk_rd,
    output logic       chk_hazard
);

    logic hit_rs0;
    logic hit_rs1;
    logic hit_rd;

    // x0 is never a real dependency, so zero indices are masked out.
    assign hit_rs0 = (chk_rs0 != 5'd0) && (chk_rs0 == pend_rd);
    assign hit_rs1 = (chk_rs1 != 5'd0) && (chk_rs1 == pend_rd);
    assign hit_rd  = (chk_rd  != 5'd0) && (chk_rd  == pend_rd);

    assign chk_hazard = pend_vld && (hit_rs0 || hit_rs1 || hit_rd);

endmodule

// File: rtl/mul_issue.sv
// Holds one RV32M op until the MUL/DIV unit is free, then tracks its rd to writeback.
// Optional statistics counters enabled by MUL_ISSUE_STAT_EN.
module mul_issue
    import mul_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    input  logic [XLEN-1:0] req_instr,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_rs0_word,
    input  logic [XLEN-1:0] req_rs1_word,
    output logic            req_rdy,
    input  logic            flush,
    output logic [XLEN-1:0] mul_instr,
    output logic [XLEN-1:0] mul_pc,
    output logic            mul_vld,
    output logic [XLEN-1:0] mul_rs0_word,
    output logic [XLEN-1:0] mul_rs1_word,
    input  logic            mul_is_busy,
    input  logic [4:0]      m2_sel,
    input  logic [4:0]      chk_rs0,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rd,
    output logic            chk_hazard,
    output logic            pend_vld,
    output logic [4:0]      pend_rd
`ifdef MUL_ISSUE_STAT_EN
    ,
    output logic [31:0]     stat_issue_cnt,
    output logic [31:0]     stat_stall_cnt,
    output logic [15:0]     stat_lat_max
`endif
);

    mis_state_e      state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs0_q, rs0_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [4:0]      rd_q, rd_d;

    logic is_m;
    logic wb_hit;
    logic accept;

    assign is_m    = is_m_op(req_instr[6:0], req_instr[25]);
    assign wb_hit  = (m2_sel == rd_q);
    assign req_rdy = (state_q == MIS_IDLE) || ((state_q == MIS_INFLIGHT) && wb_hit);
    assign accept  = req_vld && req_rdy && is_m;
    assign mul_vld = (state_q == MIS_HOLD) && !flush && !mul_is_busy;

    assign mul_instr    = instr_q;
    assign mul_pc       = pc_q;
    assign mul_rs0_word = rs0_q;
    assign mul_rs1_word = rs1_q;
    assign pend_rd      = rd_q;
    assign pend_vld     = ((state_q == MIS_HOLD) || (state_q == MIS_INFLIGHT)) && (rd_q != 5'd0);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        rs0_d   = rs0_q;
        rs1_d   = rs1_q;
        rd_d    = rd_q;
        // accept is only possible in IDLE or on the INFLIGHT writeback cycle
        if (accept) begin
            instr_d = req_instr;
            pc_d    = req_pc;
            rs0_d   = req_rs0_word;
            rs1_d   = req_rs1_word;
            rd_d    = req_instr[11:7];
        end
        case (state_q)
            MIS_IDLE: begin
                if (accept) state_d = MIS_HOLD;
            end
            MIS_HOLD: begin
                if (flush) begin
                    state_d = MIS_IDLE;
                end else if (!mul_is_busy) begin
                    state_d = (rd_q != 5'd0) ? MIS_INFLIGHT : MIS_IDLE;
                end
            end
            MIS_INFLIGHT: begin
                if (wb_hit) state_d = accept ? MIS_HOLD : MIS_IDLE;
            end
            default: state_d = MIS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MIS_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            rs0_q   <= '0;
            rs1_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            rs0_q   <= rs0_d;
            rs1_q   <= rs1_d;
            rd_q    <= rd_d;
        end
    end

    mul_issue_cmp u_cmp (
        .pend_vld   (pend_vld),
        .pend_rd    (rd_q),
        .chk_rs0    (chk_rs0),
        .chk_rs1    (chk_rs1),
        .chk_rd     (chk_rd),
        .chk_hazard (chk_hazard)
    );

`ifdef MUL_ISSUE_STAT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] lat_cnt_q, lat_cnt_d;
    logic [15:0] lat_max_q, lat_max_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(mul_vld);
        stall_cnt_d = stall_cnt_q + 32'((state_q == MIS_HOLD) && mul_is_busy);
        lat_cnt_d   = lat_cnt_q;
        lat_max_d   = lat_max_q;
        // Counter reads 1 on the first INFLIGHT cycle, i.e. cycles since issue.
        if (mul_vld) begin
            lat_cnt_d = 16'd1;
        end else if (state_q == MIS_INFLIGHT && !wb_hit && lat_cnt_q != 16'hffff) begin
            lat_cnt_d = lat_cnt_q + 16'd1;
        end
        if (state_q == MIS_INFLIGHT && wb_hit && lat_cnt_q > lat_max_q) begin
            lat_max_d = lat_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
            lat_cnt_q   <= '0;
            lat_max_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            lat_max_q   <= lat_max_d;
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
    assign stat_lat_max   = lat_max_q;
`endif

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue: vector table plus hand-written corner sequences.
module tb_mul_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic [31:0] req_instr = '0, req_pc = '0, req_rs0_word = '0, req_rs1_word = '0;
    logic        req_rdy;
    logic        flush = 1'b0;
    logic [31:0] mul_instr, mul_pc, mul_rs0_word, mul_rs1_word;
    logic        mul_vld;
    logic        mul_is_busy = 1'b0;
    logic [4:0]  m2_sel = '0, chk_rs0 = '0, chk_rs1 = '0, chk_rd = '0;
    logic        chk_hazard, pend_vld;
    logic [4:0]  pend_rd;
`ifdef MUL_ISSUE_STAT_EN
    logic [31:0] stat_issue_cnt, stat_stall_cnt;
    logic [15:0] stat_lat_max;
`endif

    mul_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_instr(req_instr), .req_pc(req_pc),
        .req_rs0_word(req_rs0_word), .req_rs1_word(req_rs1_word), .req_rdy(req_rdy),
        .flush(flush), .mul_instr(mul_instr), .mul_pc(mul_pc), .mul_vld(mul_vld),
        .mul_rs0_word(mul_rs0_word), .mul_rs1_word(mul_rs1_word), .mul_is_busy(mul_is_busy),
        .m2_sel(m2_sel), .chk_rs0(chk_rs0), .chk_rs1(chk_rs1), .chk_rd(chk_rd),
        .chk_hazard(chk_hazard), .pend_vld(pend_vld), .pend_rd(pend_rd)
`ifdef MUL_ISSUE_STAT_EN
        , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt),
        .stat_lat_max(stat_lat_max)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_issue = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
    } issue_t;

    issue_t exp_q[$];
    issue_t mon_e;
    logic   prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every issue strobe must match the oldest expected issue.
    always @(negedge clk) begin
        if (mul_vld === 1'b1) begin
            chk("vld_gap", {31'd0, prev_vld}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue act=%h exp=none t=%0t", mul_instr, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_instr", mul_instr, mon_e.instr);
                chk("sb_pc", mul_pc, mon_e.pc);
                chk("sb_w0", mul_rs0_word, mon_e.w0);
                chk("sb_w1", mul_rs1_word, mon_e.w1);
            end
        end
        prev_vld = mul_vld;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    // Offer from IDLE, stall `busy` HOLD cycles, issue, land one cycle after issue.
    task automatic do_op(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] w0,
                         input logic [31:0] w1, input int busy, input logic [4:0] rd);
        issue_t e;
        req_instr = instr; req_pc = pc; req_rs0_word = w0; req_rs1_word = w1; req_vld = 1'b1;
        #1 chk("offer_rdy", req_rdy, 1);
        e.instr = instr; e.pc = pc; e.w0 = w0; e.w1 = w1;
        exp_q.push_back(e);
        n_issue++;
        tick();
        req_vld = 1'b0;
        for (int i = 0; i < busy; i++) begin
            mul_is_busy = 1'b1;
            #1 chk("stall_vld", mul_vld, 0);
            chk("hold_pend", pend_vld, rd != 5'd0);
            tick();
        end
        mul_is_busy = 1'b0;
        #1 chk("issue_vld", mul_vld, 1);
        tick();
        #1 chk("post_pend_vld", pend_vld, rd != 5'd0);
        chk("post_pend_rd", pend_rd, rd);
    endtask

    task automatic do_wb(input logic [4:0] rd, input int dly);
        for (int i = 0; i < dly; i++) begin
            m2_sel = 5'd0;
            #1 chk("inflight_rdy", req_rdy, 0);
            chk("inflight_vld", mul_vld, 0);
            tick();
        end
        m2_sel = rd;
        #1 chk("wb_rdy", req_rdy, 1);
        tick();
        m2_sel = 5'd0;
        #1 chk("wb_done", pend_vld, 0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
        int          busy;
        int          wbdly;
        bit          is_m;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[7];
    int   lat_exp = 0;
`ifdef MUL_ISSUE_STAT_EN
    logic [31:0] stall0;
`endif

    initial begin
        vecs[0] = '{32'h022082B3, 32'h100, 32'd3, 32'd4, 0, 2, 1'b1, 5'd5};          // mul x5
        vecs[1] = '{32'h0220C3B3, 32'h104, 32'd100, 32'd7, 10, 3, 1'b1, 5'd7};       // div x7
        vecs[2] = '{32'h002082B3, 32'h108, 32'd1, 32'd2, 0, 0, 1'b0, 5'd5};          // add
        vecs[3] = '{32'h02208293, 32'h10c, 32'd1, 32'd2, 0, 0, 1'b0, 5'd5};          // op-imm
        vecs[4] = '{32'h02208033, 32'h110, 32'h5a5a5a5a, 32'ha5a5a5a5, 1, 0, 1'b1, 5'd0}; // mul x0
        vecs[5] = '{32'h024184B3, 32'h200, 32'hffffffff, 32'h80000000, 2, 0, 1'b1, 5'd9}; // mul x9
        vecs[6] = '{32'h0220FFB3, 32'h204, 32'h12345678, 32'h0, 0, 1, 1'b1, 5'd31};  // remu x31

        #2;
        chk("rst_pend_vld", pend_vld, 0);
        chk("rst_mul_vld", mul_vld, 0);
        chk("rst_mul_instr", mul_instr, 0);
        chk("rst_hazard", chk_hazard, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
`ifdef MUL_ISSUE_STAT_EN
            stall0 = stat_stall_cnt;
`endif
            if (vecs[v].is_m) begin
                do_op(vecs[v].instr, vecs[v].pc, vecs[v].w0, vecs[v].w1, vecs[v].busy, vecs[v].rd);
                if (vecs[v].rd != 5'd0) begin
                    do_wb(vecs[v].rd, vecs[v].wbdly);
                    if (vecs[v].wbdly + 1 > lat_exp) lat_exp = vecs[v].wbdly + 1;
                end else begin
                    chk("x0_idle_rdy", req_rdy, 1);
                end
`ifdef MUL_ISSUE_STAT_EN
                chk("stat_stall", stat_stall_cnt - stall0, vecs[v].busy);
                chk("stat_lat", {16'd0, stat_lat_max}, lat_exp);
`endif
            end else begin
                req_instr = vecs[v].instr; req_pc = vecs[v].pc; req_vld = 1'b1;
                #1 chk("nonm_rdy", req_rdy, 1);
                tick();
                req_vld = 1'b0;
                #1 chk("nonm_pend", pend_vld, 0);
                chk("nonm_vld", mul_vld, 0);
                chk("nonm_idle", req_rdy, 1);
            end
            tick();
        end

        // Hazard tracking through HOLD and INFLIGHT, no bypass on writeback cycle.
        req_instr = 32'h024184B3; req_pc = 32'h300; req_rs0_word = 32'd11; req_rs1_word = 32'd22;
        req_vld = 1'b1;
        #1 begin
            issue_t e;
            e.instr = 32'h024184B3; e.pc = 32'h300; e.w0 = 32'd11; e.w1 = 32'd22;
            exp_q.push_back(e);
            n_issue++;
        end
        tick();
        req_vld = 1'b0; mul_is_busy = 1'b1; chk_rs1 = 5'd9;
        #1 chk("haz_hold", chk_hazard, 1);
        mul_is_busy = 1'b0;
        #1 chk("haz_issue", mul_vld, 1);
        tick();
        #1 chk("haz_rs1", chk_hazard, 1);
        chk_rs1 = 5'd0;
        #1 chk("haz_zero", chk_hazard, 0);
        chk_rd = 5'd9;
        #1 chk("haz_rd", chk_hazard, 1);
        chk_rd = 5'd0; chk_rs0 = 5'd4;
        #1 chk("haz_other", chk_hazard, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("flush_inflight", pend_vld, 1);
        chk_rs0 = 5'd9; m2_sel = 5'd9;
        #1 chk("haz_wb_cycle", chk_hazard, 1);
        tick();
        m2_sel = 5'd0;
        #1 chk("haz_after_wb", chk_hazard, 0);
        chk_rs0 = 5'd0;
        tick();

        // Back-to-back: new offer accepted on the writeback cycle.
        do_op(32'h022081B3, 32'h400, 32'd6, 32'd7, 0, 5'd3);
        req_instr = 32'h02209233; req_pc = 32'h404; req_rs0_word = 32'd8; req_rs1_word = 32'd9;
        req_vld = 1'b1;
        #1 chk("b2b_blocked", req_rdy, 0);
        tick();
        m2_sel = 5'd3;
        #1 chk("b2b_rdy", req_rdy, 1);
        begin
            issue_t e;
            e.instr = 32'h02209233; e.pc = 32'h404; e.w0 = 32'd8; e.w1 = 32'd9;
            exp_q.push_back(e);
            n_issue++;
        end
        tick();
        req_vld = 1'b0; m2_sel = 5'd0; mul_is_busy = 1'b1;
        #1 chk("b2b_pend_rd", pend_rd, 4);
        chk("b2b_pend_vld", pend_vld, 1);
        chk("b2b_busy_vld", mul_vld, 0);
        chk("b2b_instr", mul_instr, 32'h02209233);
        mul_is_busy = 1'b0;
        #1 chk("b2b_issue", mul_vld, 1);
        tick();
        do_wb(5'd4, 0);
        tick();

        // Flush in HOLD: rd=0 op with flush winning over a free unit, then rd=5 while busy.
        req_instr = 32'h02208033; req_vld = 1'b1;
        tick();
        req_vld = 1'b0; mul_is_busy = 1'b1; chk_rs0 = 5'd0;
        #1 chk("x0_haz", chk_hazard, 0);
        chk("x0_pend", pend_vld, 0);
        tick();
        flush = 1'b1; mul_is_busy = 1'b0;
        #1 chk("flush_prio", mul_vld, 0);
        tick();
        flush = 1'b0;
        #1 chk("flush_idle", req_rdy, 1);
        chk("flush_novld", mul_vld, 0);
        req_instr = 32'h022082B3; req_vld = 1'b1;
        tick();
        req_vld = 1'b0; mul_is_busy = 1'b1;
        #1 chk("flush5_pend", pend_vld, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0; mul_is_busy = 1'b0;
        #1 chk("flush5_pend_off", pend_vld, 0);
        chk("flush5_novld", mul_vld, 0);
        tick();

`ifdef MUL_ISSUE_STAT_EN
        chk("stat_issue", stat_issue_cnt, n_issue);
`endif

        // Asynchronous reset while INFLIGHT.
        do_op(32'h022082B3, 32'h500, 32'd3, 32'd4, 0, 5'd5);
        chk_rs0 = 5'd5;
        #2 rst = 1'b1;
        #1 chk("arst_pend_vld", pend_vld, 0);
        chk("arst_pend_rd", pend_rd, 0);
        chk("arst_instr", mul_instr, 0);
        chk("arst_pc", mul_pc, 0);
        chk("arst_w0", mul_rs0_word, 0);
        chk("arst_w1", mul_rs1_word, 0);
        chk("arst_hazard", chk_hazard, 0);
        chk("arst_vld", mul_vld, 0);
`ifdef MUL_ISSUE_STAT_EN
        chk("arst_stat_issue", stat_issue_cnt, 0);
        chk("arst_stat_stall", stat_stall_cnt, 0);
        chk("arst_stat_lat", {16'd0, stat_lat_max}, 0);
`endif
        chk_rs0 = 5'd0;
        tick();
        rst = 1'b0;
        tick();
        #1 chk("post_rst_idle", req_rdy, 1);
        chk("post_rst_pend", pend_vld, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
